// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the multiplier result drain.
package mul_pkg;

  // Result bus width and product width (product is exactly two result words).
  localparam int OUT_W  = 32;
  localparam int DATA_W = 64;

  // Drain sequencing: nothing held, low word on the bus, high word on the bus.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } drain_state_t;

endpackage

// File: rtl/mul_result_drain_if.sv
// Handshake bundle between the multiplier register, the drain and the ALU
// result bus. The slave modport is the drain itself; master is its environment.
interface mul_result_drain_if;
  import mul_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_half;
  logic              in_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              out_hi;
  logic              out_ready;
  logic              busy;

  modport slave (
    input  in_valid, in_data, in_half, out_ready,
    output in_ready, out_valid, out_data, out_last, out_hi, busy
  );

  modport master (
    output in_valid, in_data, in_half, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_hi, busy
  );

endinterface

// File: rtl/product_hold_reg.sv
// Enabled holding register for the captured product and its half flag.
module product_hold_reg #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] hold_q;

  // Capture on enable; reset clears so no stale product survives a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else if (en_i) begin
      hold_q <= d_i;
    end
  end

  assign q_o = hold_q;

endmodule

// File: rtl/mul_result_drain.sv
// Drains a held 64-bit product onto the 32-bit result bus as low then high
// word (or low word only for low-half ops), with backpressure upstream.
module mul_result_drain #(
  parameter int OUT_W  = mul_pkg::OUT_W,
  parameter int DATA_W = mul_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  mul_result_drain_if.slave   bus
);
  import mul_pkg::*;

  drain_state_t      state_q, state_d;
  logic [DATA_W-1:0] hold_q;
  logic              half_q;
  logic              accept;
  logic              in_ready_c;
  logic              out_valid_c;
  logic [OUT_W-1:0]  out_data_c;
  logic              out_hi_c;
  logic              out_last_c;

  // Product and half flag are only written on an accepted handshake, so the
  // bus stays stable for the whole time a word is stalled.
  product_hold_reg #(
    .W(DATA_W + 1)
  ) u_hold (
    .clk   (clk),
    .reset (reset),
    .en_i  (accept),
    .d_i   ({bus.in_half, bus.in_data}),
    .q_o   ({half_q, hold_q})
  );

  // Accept when empty, or when the final word leaves this cycle; in_ready
  // depends only on state and out_ready, never on in_valid.
  assign in_ready_c = (state_q == IDLE) || (out_valid_c && bus.out_ready && out_last_c);
  assign accept     = bus.in_valid && in_ready_c;

  // State register; reset discards any product mid-drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance only on the output handshake, reload on a same-cycle accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SEND_LO;
      end
      SEND_LO: begin
        if (bus.out_ready) begin
          if (!half_q)     state_d = SEND_HI;
          else if (accept) state_d = SEND_LO;
          else             state_d = IDLE;
        end
      end
      SEND_HI: begin
        if (bus.out_ready) state_d = accept ? SEND_LO : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux: select the half of the held product for the current state.
  always_comb begin
    out_valid_c = 1'b0;
    out_data_c  = '0;
    out_hi_c    = 1'b0;
    out_last_c  = 1'b0;
    unique case (state_q)
      SEND_LO: begin
        out_valid_c = 1'b1;
        out_data_c  = hold_q[OUT_W-1:0];
        out_last_c  = half_q;
      end
      SEND_HI: begin
        out_valid_c = 1'b1;
        out_data_c  = hold_q[DATA_W-1:OUT_W];
        out_hi_c    = 1'b1;
        out_last_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_hi    = out_hi_c;
  assign bus.out_last  = out_last_c;
  assign bus.busy      = out_valid_c;

endmodule

// File: tb/tb_mul_result_drain.sv
// Bench for mul_result_drain: directed scenarios plus a random phase, all
// checked against a queue of pending result words.
module tb_mul_result_drain;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_result_drain_if bus ();

  mul_result_drain dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] word;
    logic        hi;
    logic        last;
  } word_t;

  word_t model_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare outputs against the pending-word queue, then advance
  // the queue by the handshakes that happen on the edge.
  task automatic cycle(output logic acc);
    logic        ev, eh, el, er, hs;
    logic [31:0] ed;
    word_t       w;
    #1;
    if (model_q.size() == 0) begin
      ev = 1'b0; ed = '0; eh = 1'b0; el = 1'b0;
    end else begin
      ev = 1'b1; ed = model_q[0].word; eh = model_q[0].hi; el = model_q[0].last;
    end
    er = (model_q.size() == 0) || (model_q.size() == 1 && bus.out_ready);
    check("out_valid", 64'(bus.out_valid), 64'(ev));
    check("out_data",  64'(bus.out_data),  64'(ed));
    check("out_hi",    64'(bus.out_hi),    64'(eh));
    check("out_last",  64'(bus.out_last),  64'(el));
    check("in_ready",  64'(bus.in_ready),  64'(er));
    check("busy",      64'(bus.busy),      64'(ev));
    acc = bus.in_valid && er && !reset;
    hs  = ev && bus.out_ready;
    $display("t=%0t rst=%0b iv=%0b ir=%0b ov=%0b or=%0b data=%h hi=%0b last=%0b",
             $time, reset, bus.in_valid, bus.in_ready, bus.out_valid, bus.out_ready,
             bus.out_data, bus.out_hi, bus.out_last);
    @(posedge clk);
    if (reset) begin
      model_q.delete();
    end else begin
      if (hs) void'(model_q.pop_front());
      if (acc) begin
        w.word = bus.in_data[31:0]; w.hi = 1'b0; w.last = bus.in_half;
        model_q.push_back(w);
        if (!bus.in_half) begin
          w.word = bus.in_data[63:32]; w.hi = 1'b1; w.last = 1'b1;
          model_q.push_back(w);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] d, input logic h);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_half  = h;
    for (int i = 0; i < 20 && !acc; i++) cycle(acc);
    bus.in_valid = 1'b0;
    check("accept", 64'(acc), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    logic        acc;
    logic        cur_v, cur_h;
    logic [63:0] cur_d;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_half   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset then idle
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(3);

    // Full product drain
    send(64'h8484848484848484, 1'b0);
    idle_cycles(3);

    // Back-to-back full products
    send(64'h8484848484848484, 1'b0);
    send(64'h4848484848484848, 1'b0);
    idle_cycles(3);

    // Half op
    send(64'hDEADBEEF_12345678, 1'b1);
    idle_cycles(2);

    // Backpressure during the high word, with a blocked upstream product
    send(64'h00000001_FFFFFFFF, 1'b0);
    cycle(acc);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hCAFEF00D_0BADBEEF;
    bus.in_half   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      check("stall_data", 64'(bus.out_data), 64'h00000001);
      check("stall_acc", 64'(acc), 64'd0);
    end
    bus.out_ready = 1'b1;
    cycle(acc);
    check("stall_release_acc", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
    idle_cycles(3);

    // Reset mid-drain
    send(64'h11112222_33334444, 1'b0);
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    cycle(acc);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    idle_cycles(3);

    // Reset in the same cycle as in_valid: nothing captured
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h55556666_77778888;
    cycle(acc);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    idle_cycles(2);

    // Randomised traffic with an upstream that holds data until accepted
    cur_v = 1'b0; cur_h = 1'b0; cur_d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!cur_v) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_h = $urandom_range(0, 1) == 1;
        cur_d = {$urandom, $urandom};
      end
      bus.in_valid  = cur_v;
      bus.in_data   = cur_d;
      bus.in_half   = cur_h;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 59) == 0);
      cycle(acc);
      if (acc) cur_v = 1'b0;
    end
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
